// File: rtl/ceps_buffer.sv
// Result store shared by a DATA_WIDTH accelerator port and a 32-bit host lane port, arbitrated fairly
// over one lane-enabled single-port RAM. Optional macro CEPS_BUFFER_ERR_EN adds out-of-range error outputs.
module ceps_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int CTRL_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ceps_cyc_i,
  input  logic                  ceps_stb_i,
  input  logic                  ceps_we_i,
  output logic                  ceps_ack_o,
  input  logic [ADDR_WIDTH-1:0] ceps_addr_i,
  input  logic [DATA_WIDTH-1:0] ceps_mosi_i,
  output logic [DATA_WIDTH-1:0] ceps_miso_o,
  input  logic                  host_cyc_i,
  input  logic                  host_stb_i,
  input  logic                  host_we_i,
  output logic                  host_ack_o,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [CTRL_WIDTH-1:0] host_mosi_i,
  output logic [CTRL_WIDTH-1:0] host_miso_o
`ifdef CEPS_BUFFER_ERR_EN
  ,
  output logic                  ceps_err_o,
  output logic                  host_err_o
`endif
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK, S_TURN} state_e;
  typedef enum logic {P_ACCEL, P_HOST} port_e;

  state_e                state_q, state_d;
  port_e                 owner_q, owner_d;
  port_e                 last_q, last_d;
  logic [2:0]            lane_q, lane_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] ceps_miso_q, ceps_miso_d;
  logic [CTRL_WIDTH-1:0] host_miso_q, host_miso_d;

  logic                  ram_we, ram_re;
  logic [IDX_W-1:0]      ram_idx;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [LANES-1:0]      ram_be;
  logic [DATA_WIDTH-1:0] ram_rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ceps_req, host_req, grant_host, sel_we, sel_oor;
  logic                  ceps_oor, host_oor;
  logic [IDX_W-1:0]      ceps_idx, host_idx;
  logic [2:0]            host_lane;
  logic [CTRL_WIDTH-1:0] host_lane_rd;
  logic                  unused_addr;

  assign ceps_req  = ceps_cyc_i & ceps_stb_i;
  assign host_req  = host_cyc_i & host_stb_i;
  assign ceps_idx  = ceps_addr_i[5 +: IDX_W];
  assign host_idx  = host_addr_i[5 +: IDX_W];
  assign host_lane = host_addr_i[4:2];

`ifdef CEPS_BUFFER_ERR_EN
  assign ceps_oor    = |ceps_addr_i[ADDR_WIDTH-1:5+IDX_W];
  assign host_oor    = |host_addr_i[ADDR_WIDTH-1:5+IDX_W];
  assign unused_addr = ^{ceps_addr_i[4:0], host_addr_i[1:0]};
`else
  // Upper address bits are don't-care here, so indices wrap modulo DEPTH.
  assign ceps_oor    = 1'b0;
  assign host_oor    = 1'b0;
  assign unused_addr = ^{ceps_addr_i[ADDR_WIDTH-1:5+IDX_W], ceps_addr_i[4:0],
                         host_addr_i[ADDR_WIDTH-1:5+IDX_W], host_addr_i[1:0]};
`endif

  // Contention goes to whichever port was not served last.
  assign grant_host   = host_req & (~ceps_req | (last_q == P_ACCEL));
  assign sel_we       = grant_host ? host_we_i : ceps_we_i;
  assign sel_oor      = grant_host ? host_oor : ceps_oor;
  assign host_lane_rd = ram_rdata_q[CTRL_WIDTH*lane_q +: CTRL_WIDTH];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lane_d      = lane_q;
    err_d       = err_q;
    ceps_miso_d = ceps_miso_q;
    host_miso_d = host_miso_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_idx     = ceps_idx;
    ram_wdata   = ceps_mosi_i;
    ram_be      = '1;

    unique case (state_q)
      S_IDLE: begin
        if (ceps_req | host_req) begin
          owner_d = grant_host ? P_HOST : P_ACCEL;
          last_d  = grant_host ? P_HOST : P_ACCEL;
          err_d   = sel_oor;
          if (grant_host) begin
            ram_idx   = host_idx;
            ram_wdata = {LANES{host_mosi_i}};
            lane_d    = host_lane;
            for (int l = 0; l < LANES; l++) begin
              ram_be[l] = (host_lane == 3'(l));
            end
          end
          if (sel_oor) begin
            state_d = S_ACK;
          end else if (sel_we) begin
            ram_we  = 1'b1;
            state_d = S_ACK;
          end else begin
            ram_re  = 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_ACK;
        if (owner_q == P_HOST) begin
          host_miso_d = host_lane_rd;
        end else begin
          ceps_miso_d = ram_rdata_q;
        end
      end
      S_ACK: begin
        state_d = S_TURN;
      end
      S_TURN: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= P_ACCEL;
      last_q      <= P_HOST;
      lane_q      <= '0;
      err_q       <= 1'b0;
      ceps_miso_q <= '0;
      host_miso_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      ceps_miso_q <= ceps_miso_d;
      host_miso_q <= host_miso_d;
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map onto a real memory macro.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (ram_be[l]) begin
          mem[ram_idx][32*l +: 32] <= ram_wdata[32*l +: 32];
        end
      end
    end
    if (ram_re) begin
      ram_rdata_q <= mem[ram_idx];
    end
  end

  // Acks are gated by cyc_i so a master that abandoned its cycle sees nothing.
  assign ceps_ack_o  = (state_q == S_ACK) & (owner_q == P_ACCEL) & ~err_q & ceps_cyc_i;
  assign host_ack_o  = (state_q == S_ACK) & (owner_q == P_HOST) & ~err_q & host_cyc_i;
  assign ceps_miso_o = ceps_miso_q;
  assign host_miso_o = host_miso_q;

`ifdef CEPS_BUFFER_ERR_EN
  assign ceps_err_o = (state_q == S_ACK) & (owner_q == P_ACCEL) & err_q & ceps_cyc_i;
  assign host_err_o = (state_q == S_ACK) & (owner_q == P_HOST) & err_q & host_cyc_i;
`endif

endmodule

// File: tb/tb_ceps_buffer.sv
// Directed bench for ceps_buffer: latency, lane access, arbitration fairness, reset abort, address range.
module tb_ceps_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ceps_cyc = 1'b0, ceps_stb = 1'b0, ceps_we = 1'b0;
  logic         ceps_ack;
  logic [31:0]  ceps_addr = '0;
  logic [255:0] ceps_mosi = '0;
  logic [255:0] ceps_miso;
  logic         host_cyc = 1'b0, host_stb = 1'b0, host_we = 1'b0;
  logic         host_ack;
  logic [31:0]  host_addr = '0;
  logic [31:0]  host_mosi = '0;
  logic [31:0]  host_miso;
  logic         ceps_err, host_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ceps_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ceps_cyc_i  (ceps_cyc),
    .ceps_stb_i  (ceps_stb),
    .ceps_we_i   (ceps_we),
    .ceps_ack_o  (ceps_ack),
    .ceps_addr_i (ceps_addr),
    .ceps_mosi_i (ceps_mosi),
    .ceps_miso_o (ceps_miso),
    .host_cyc_i  (host_cyc),
    .host_stb_i  (host_stb),
    .host_we_i   (host_we),
    .host_ack_o  (host_ack),
    .host_addr_i (host_addr),
    .host_mosi_i (host_mosi),
    .host_miso_o (host_miso)
`ifdef CEPS_BUFFER_ERR_EN
    ,
    .ceps_err_o  (ceps_err),
    .host_err_o  (host_err)
`endif
  );

`ifndef CEPS_BUFFER_ERR_EN
  assign ceps_err = 1'b0;
  assign host_err = 1'b0;
`endif

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ceps_xfer(input logic [31:0] addr, input logic we, input logic [255:0] wd,
                           output logic [255:0] rd, output int lat,
                           output logic got_ack, output logic got_err);
    @(posedge clk); #1;
    ceps_cyc = 1'b1; ceps_stb = 1'b1; ceps_we = we; ceps_addr = addr; ceps_mosi = wd;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    while (!(got_ack || got_err) && lat < 10) begin
      @(posedge clk); lat++;
      @(negedge clk);
      got_ack = ceps_ack; got_err = ceps_err; rd = ceps_miso;
    end
    @(posedge clk); #1;
    ceps_cyc = 1'b0; ceps_stb = 1'b0; ceps_we = 1'b0;
    @(posedge clk);
  endtask

  task automatic host_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output logic got_ack);
    @(posedge clk); #1;
    host_cyc = 1'b1; host_stb = 1'b1; host_we = we; host_addr = addr; host_mosi = wd;
    lat = 0; got_ack = 1'b0; rd = '0;
    while (!(got_ack || host_err) && lat < 10) begin
      @(posedge clk); lat++;
      @(negedge clk);
      got_ack = host_ack; rd = host_miso;
    end
    @(posedge clk); #1;
    host_cyc = 1'b0; host_stb = 1'b0; host_we = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [255:0] rd;
    logic [31:0]  hrd;
    int           lat;
    logic         ack, err;
    logic [255:0] pat_a5, pat_idx5, exp3, d0, dx;
    int           order [8];
    int           n, na, nh;
    logic         a_gap, h_gap, overlap, seen_ack;

    pat_a5   = {32{8'hA5}};
    pat_idx5 = {32'h1111_0007, 32'h1111_0006, 32'h1111_0005, 32'h1111_0004,
                32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    exp3     = {{6{32'hA5A5_A5A5}}, 32'hDEAD_BEEF, 32'hA5A5_A5A5};
    d0       = {8{32'h0000_600D}};
    dx       = {8{32'hBAD0_BAD0}};

    // Reset values
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ceps_ack", ceps_ack, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_ceps_miso", ceps_miso, 0);
    check("rst_host_miso", host_miso, 0);
`ifdef CEPS_BUFFER_ERR_EN
    check("rst_ceps_err", ceps_err, 0);
    check("rst_host_err", host_err, 0);
`endif
    rst_n = 1'b1;

    // Contention: both masters re-request right after each ack; grants must alternate from accel
    @(posedge clk); #1;
    ceps_cyc = 1'b1; ceps_stb = 1'b1; ceps_we = 1'b1; ceps_addr = 32'h140; ceps_mosi = {8{32'h0A0A_0A0A}};
    host_cyc = 1'b1; host_stb = 1'b1; host_we = 1'b1; host_addr = 32'h160; host_mosi = 32'h0B0B_0B0B;
    n = 0; na = 4; nh = 4; a_gap = 1'b0; h_gap = 1'b0; overlap = 1'b0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk);
      if (ceps_ack && host_ack) overlap = 1'b1;
      if (ceps_ack) begin
        if (n < 8) order[n] = 0;
        n++; na--; a_gap = 1'b1;
      end
      if (host_ack) begin
        if (n < 8) order[n] = 1;
        n++; nh--; h_gap = 1'b1;
      end
      @(posedge clk); #1;
      if (a_gap) begin
        ceps_cyc = 1'b0; ceps_stb = 1'b0; a_gap = 1'b0;
      end else if (na > 0) begin
        ceps_cyc = 1'b1; ceps_stb = 1'b1;
      end
      if (h_gap) begin
        host_cyc = 1'b0; host_stb = 1'b0; h_gap = 1'b0;
      end else if (nh > 0) begin
        host_cyc = 1'b1; host_stb = 1'b1;
      end
    end
    ceps_cyc = 1'b0; ceps_stb = 1'b0; ceps_we = 1'b0;
    host_cyc = 1'b0; host_stb = 1'b0; host_we = 1'b0;
    repeat (2) @(posedge clk);
    check("arb_ack_count", n, 8);
    check("arb_no_overlap", overlap, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("arb_grant%0d", i), order[i], i % 2);
    end

    // Accel write then read of idx 3
    ceps_xfer(32'h60, 1'b1, pat_a5, rd, lat, ack, err);
    check("wr3_ack", ack, 1);
    check("wr3_latency", lat, 1);
    ceps_xfer(32'h60, 1'b0, '0, rd, lat, ack, err);
    check("rd3_ack", ack, 1);
    check("rd3_latency", lat, 2);
    check("rd3_data", rd, pat_a5);

    // Accel writes idx 5, host reads lane 2 of it
    ceps_xfer(32'hA0, 1'b1, pat_idx5, rd, lat, ack, err);
    check("wr5_ack", ack, 1);
    check("miso_hold_after_write", ceps_miso, pat_a5);
    host_xfer(32'hA8, 1'b0, '0, hrd, lat, ack);
    check("host_rd_ack", ack, 1);
    check("host_rd_latency", lat, 2);
    check("host_rd_idx5_lane2", hrd, 32'h1111_0002);

    // Host patches idx 3 lane 1, accel sees only that lane change
    host_xfer(32'h64, 1'b1, 32'hDEAD_BEEF, hrd, lat, ack);
    check("host_wr_latency", lat, 1);
    check("host_miso_hold", host_miso, 32'h1111_0002);
    ceps_xfer(32'h60, 1'b0, '0, rd, lat, ack, err);
    check("rd3_after_patch", rd, exp3);

    // Reset in the middle of a read
    @(posedge clk); #1;
    ceps_cyc = 1'b1; ceps_stb = 1'b1; ceps_we = 1'b0; ceps_addr = 32'h60;
    @(posedge clk);
    @(negedge clk);
    seen_ack = ceps_ack;
    rst_n = 1'b0;
    #1;
    check("rstmid_ceps_ack", ceps_ack, 0);
    check("rstmid_ceps_miso", ceps_miso, 0);
    check("rstmid_host_miso", host_miso, 0);
    ceps_cyc = 1'b0; ceps_stb = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen_ack = seen_ack | ceps_ack;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen_ack = seen_ack | ceps_ack;
    end
    check("rstmid_no_ack", seen_ack, 0);
    ceps_xfer(32'h60, 1'b0, '0, rd, lat, ack, err);
    check("rd3_after_reset", rd, exp3);

    // Out-of-range accel address 0x800
    ceps_xfer(32'h0, 1'b1, d0, rd, lat, ack, err);
    check("wr0_ack", ack, 1);
    ceps_xfer(32'h800, 1'b1, dx, rd, lat, ack, err);
`ifdef CEPS_BUFFER_ERR_EN
    check("oor_wr_err", err, 1);
    check("oor_wr_no_ack", ack, 0);
`else
    check("alias_wr_ack", ack, 1);
    check("alias_wr_latency", lat, 1);
`endif
    check("miso_hold_oor_wr", ceps_miso, exp3);
    ceps_xfer(32'h800, 1'b0, '0, rd, lat, ack, err);
`ifdef CEPS_BUFFER_ERR_EN
    check("oor_rd_err", err, 1);
    check("oor_rd_miso_unchanged", ceps_miso, exp3);
`else
    check("alias_rd_ack", ack, 1);
    check("alias_rd_data", rd, dx);
`endif
    ceps_xfer(32'h0, 1'b0, '0, rd, lat, ack, err);
    check("rd0_ack", ack, 1);
`ifdef CEPS_BUFFER_ERR_EN
    check("rd0_intact", rd, d0);
`else
    check("rd0_aliased", rd, dx);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
